// File: rtl/uart_boot_loader.sv
// Power-up boot loader: parses a framed image from the UART byte stream, writes it
// word by word into instruction memory, and releases the core once the checksum matches.
//
// state   | meaning
// --------+---------------------------------------------------------------
// S_IDLE  | waiting for the frame start byte, other bytes dropped
// S_LEN0  | expecting low byte of the word count
// S_LEN1  | expecting high byte of the word count
// S_DATA  | assembling the next payload word, little-endian
// S_WRITE | memory write request outstanding until acknowledged
// S_CHECK | expecting the XOR checksum byte
// S_DONE  | image verified, core released, input ignored
// S_ERROR | load failed, waiting for a fresh frame start byte
module uart_boot_loader #(
  parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
  parameter logic [7:0]  MAGIC          = 8'hA5,
  parameter int unsigned TIMEOUT_CYCLES = 2_000_000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        rxFin,
  input  logic [7:0]  rxData,
  output logic        memReq,
  output logic [31:0] memAddr,
  output logic [31:0] memData,
  input  logic        memAck,
  output logic        cpuResetN,
  output logic        busy,
  output logic        loadError
);

  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LEN0, S_LEN1, S_DATA, S_WRITE, S_CHECK, S_DONE, S_ERROR
  } state_t;

  state_t        state;
  logic          rx_fin_q;
  logic [TW-1:0] tmo_cnt;
  logic [15:0]   len;
  logic [15:0]   word_idx;
  logic [1:0]    byte_idx;
  logic [23:0]   word;
  logic [7:0]    chk;

  logic evt;
  logic counting;
  logic tmo_hit;

  // one event per strobe, however long rxFin stays high
  assign evt      = rxFin & ~rx_fin_q;
  assign counting = (state == S_LEN0) || (state == S_LEN1) ||
                    (state == S_DATA) || (state == S_CHECK);
  assign tmo_hit  = counting && !evt && (tmo_cnt == TMO_LAST);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      rx_fin_q  <= 1'b0;
      tmo_cnt   <= '0;
      len       <= '0;
      word_idx  <= '0;
      byte_idx  <= '0;
      word      <= '0;
      chk       <= '0;
      memReq    <= 1'b0;
      memAddr   <= '0;
      memData   <= '0;
      cpuResetN <= 1'b0;
      busy      <= 1'b0;
      loadError <= 1'b0;
    end else begin
      rx_fin_q <= rxFin;

      // timer holds while a write is outstanding so slow memory never times out
      if (evt)
        tmo_cnt <= '0;
      else if (counting && !tmo_hit)
        tmo_cnt <= tmo_cnt + TW'(1);

      if (tmo_hit) begin
        state     <= S_ERROR;
        busy      <= 1'b0;
        loadError <= 1'b1;
      end else begin
        case (state)
          S_IDLE: begin
            if (evt && rxData == MAGIC) begin
              chk      <= '0;
              word_idx <= '0;
              byte_idx <= '0;
              busy     <= 1'b1;
              state    <= S_LEN0;
            end
          end
          S_LEN0: begin
            if (evt) begin
              len[7:0] <= rxData;
              state    <= S_LEN1;
            end
          end
          S_LEN1: begin
            if (evt) begin
              len[15:8] <= rxData;
              state     <= ({rxData, len[7:0]} == 16'd0) ? S_CHECK : S_DATA;
            end
          end
          S_DATA: begin
            if (evt) begin
              chk      <= chk ^ rxData;
              byte_idx <= byte_idx + 2'd1;
              case (byte_idx)
                2'd0: word[7:0]   <= rxData;
                2'd1: word[15:8]  <= rxData;
                2'd2: word[23:16] <= rxData;
                default: begin
                  memReq  <= 1'b1;
                  memAddr <= BASE_ADDR + {14'd0, word_idx, 2'b00};
                  memData <= {rxData, word};
                  state   <= S_WRITE;
                end
              endcase
            end
          end
          S_WRITE: begin
            // a byte arriving before the write lands means the sender overran us
            if (evt) begin
              memReq    <= 1'b0;
              busy      <= 1'b0;
              loadError <= 1'b1;
              state     <= S_ERROR;
            end else if (memAck) begin
              memReq   <= 1'b0;
              word_idx <= word_idx + 16'd1;
              state    <= ((word_idx + 16'd1) == len) ? S_CHECK : S_DATA;
            end
          end
          S_CHECK: begin
            if (evt) begin
              busy <= 1'b0;
              if (rxData == chk) begin
                state <= S_DONE;
              end else begin
                loadError <= 1'b1;
                state     <= S_ERROR;
              end
            end
          end
          S_DONE: begin
            cpuResetN <= 1'b1;
          end
          S_ERROR: begin
            if (evt && rxData == MAGIC) begin
              loadError <= 1'b0;
              chk       <= '0;
              word_idx  <= '0;
              byte_idx  <= '0;
              busy      <= 1'b1;
              state     <= S_LEN0;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_boot_loader.sv
// Bench for uart_boot_loader: frames are built from word lists, expected writes go into a
// scoreboard queue, and a separate monitor checks each acknowledged memory write.
module tb_uart_boot_loader;

  localparam logic [31:0] BASE  = 32'h0000_0100;
  localparam logic [7:0]  MAGIC = 8'hA5;
  localparam int          TMO   = 200;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rx_fin = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] mem_data;
  logic        mem_ack = 1'b0;
  logic        cpu_reset_n;
  logic        busy;
  logic        load_error;

  uart_boot_loader #(
    .BASE_ADDR     (BASE),
    .MAGIC         (MAGIC),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clock    (clk),
    .reset    (rst_n),
    .rxFin    (rx_fin),
    .rxData   (rx_data),
    .memReq   (mem_req),
    .memAddr  (mem_addr),
    .memData  (mem_data),
    .memAck   (mem_ack),
    .cpuResetN(cpu_reset_n),
    .busy     (busy),
    .loadError(load_error)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t         exp_q[$];
  wr_t         exp_w;
  int          checks = 0;
  int          failures = 0;
  int          ack_delay = 0;
  bit          ack_en = 1'b1;
  logic [31:0] hold_a;
  logic [31:0] hold_d;
  int          waited;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // scoreboard monitor: every accepted write must match the next expected one
  always @(negedge clk) begin
    if (rst_n && mem_req && mem_ack) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_write: got addr %h data %h expected no write", mem_addr, mem_data);
      end else begin
        exp_w = exp_q.pop_front();
        check("write_addr", mem_addr, exp_w.addr);
        check("write_data", mem_data, exp_w.data);
      end
    end
  end

  // memory model: acks after ack_delay cycles, request must stay stable meanwhile
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && mem_req && ack_en) begin
        hold_a = mem_addr;
        hold_d = mem_data;
        waited = 0;
        while (mem_req && waited < ack_delay) begin
          @(negedge clk);
          waited++;
          if (mem_req) begin
            check("hold_addr", mem_addr, hold_a);
            check("hold_data", mem_data, hold_d);
          end
        end
        if (mem_req) begin
          @(posedge clk); #1 mem_ack = 1'b1;
          @(posedge clk); #1 mem_ack = 1'b0;
        end
      end
    end
  end

  // all drivers assume they start at posedge+1 and return there
  task automatic send_byte(input logic [7:0] b, input int hold, input int gap);
    rx_data = b;
    rx_fin  = 1'b1;
    repeat (hold) @(posedge clk);
    #1;
    rx_fin  = 1'b0;
    rx_data = 8'($urandom);
    repeat (gap) @(posedge clk);
    #1;
  endtask

  task automatic rnd_byte(input logic [7:0] b, input int hold_max);
    send_byte(b, $urandom_range(1, hold_max), $urandom_range(1, 3));
  endtask

  task automatic wait_no_req();
    int n = 0;
    while (mem_req && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (mem_req) begin
      checks++;
      failures++;
      $display("FAIL write_wait_timeout: got memReq 1 expected 0 within 200 cycles");
    end
  endtask

  // reference: frame = MAGIC, N (LE16), words LE, XOR of payload (optionally corrupted)
  task automatic send_frame(input logic [31:0] w[$], input logic [7:0] corrupt, input int hold_max);
    logic [7:0] x = 8'h00;
    logic [7:0] b;
    int n = w.size();
    rnd_byte(MAGIC, hold_max);
    rnd_byte(n[7:0], hold_max);
    rnd_byte(n[15:8], hold_max);
    for (int i = 0; i < n; i++) begin
      exp_q.push_back('{BASE + 32'(4 * i), w[i]});
      for (int k = 0; k < 4; k++) begin
        b = w[i][8*k +: 8];
        x = x ^ b;
        rnd_byte(b, hold_max);
      end
      wait_no_req();
    end
    rnd_byte(x ^ corrupt, hold_max);
  endtask

  task automatic finish_check(input bit ok);
    repeat (4) @(posedge clk);
    #1;
    check("cpu_reset_n", 32'(cpu_reset_n), 32'(ok));
    check("load_error", 32'(load_error), 32'(!ok));
    check("busy_end", 32'(busy), 32'd0);
    check("writes_pending", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic do_reset();
    rst_n  = 1'b0;
    rx_fin = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    exp_q.delete();
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_memReq"}, 32'(mem_req), 32'd0);
    check({tag, "_memAddr"}, mem_addr, 32'd0);
    check({tag, "_memData"}, mem_data, 32'd0);
    check({tag, "_cpuResetN"}, 32'(cpu_reset_n), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_loadError"}, 32'(load_error), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish expected finish within 1ms");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] wq[$];
    logic [7:0]  corrupt;

    #12;
    check_all_zero("reset");
    do_reset();

    // single word, immediate ack
    wq = '{32'h1234_5678};
    ack_delay = 0;
    send_frame(wq, 8'h00, 2);
    finish_check(1'b1);

    // same frame, slow memory
    do_reset();
    ack_delay = 10;
    send_frame(wq, 8'h00, 2);
    finish_check(1'b1);

    // two words, good then bad checksum (0x03 -> 0x04)
    do_reset();
    ack_delay = 2;
    wq = '{32'h0000_0001, 32'h0000_0002};
    send_frame(wq, 8'h00, 3);
    finish_check(1'b1);
    do_reset();
    send_frame(wq, 8'h07, 3);
    finish_check(1'b0);

    // stray bytes, long strobes, empty image
    do_reset();
    send_byte(8'h00, 50, 2);
    send_byte(8'hFF, 50, 2);
    check("stray_busy", 32'(busy), 32'd0);
    wq.delete();
    send_frame(wq, 8'h00, 50);
    finish_check(1'b1);

    // inter-byte timeout, then recovery with a valid frame
    do_reset();
    send_byte(MAGIC, 1, 2);
    send_byte(8'h01, 1, 2);
    send_byte(8'h00, 1, 2);
    send_byte(8'h11, 1, 2);
    send_byte(8'h22, 1, 2);
    check("pre_timeout_busy", 32'(busy), 32'd1);
    repeat (TMO + 20) @(posedge clk);
    #1;
    check("timeout_error", 32'(load_error), 32'd1);
    check("timeout_busy", 32'(busy), 32'd0);
    check("timeout_req", 32'(mem_req), 32'd0);
    wq = '{32'($urandom), 32'($urandom), 32'($urandom)};
    send_frame(wq, 8'h00, 4);
    finish_check(1'b1);

    // randomized frames with random latency and occasional bad checksums
    for (int it = 0; it < 6; it++) begin
      do_reset();
      wq.delete();
      for (int i = 0; i < int'($urandom_range(1, 5)); i++) wq.push_back(32'($urandom));
      corrupt = ($urandom_range(0, 2) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
      ack_delay = $urandom_range(0, 6);
      send_frame(wq, corrupt, $urandom_range(1, 8));
      finish_check(corrupt == 8'h00);
    end

    // overrun: byte strobe while the write is still pending
    do_reset();
    ack_en = 1'b0;
    send_byte(MAGIC, 1, 2);
    send_byte(8'h01, 1, 2);
    send_byte(8'h00, 1, 2);
    send_byte(8'h0D, 1, 2);
    send_byte(8'hF0, 1, 2);
    send_byte(8'hFE, 1, 2);
    send_byte(8'hCA, 1, 2);
    check("overrun_req_up", 32'(mem_req), 32'd1);
    check("overrun_addr", mem_addr, BASE);
    check("overrun_data", mem_data, 32'hCAFE_F00D);
    send_byte(8'h33, 1, 2);
    check("overrun_req_drop", 32'(mem_req), 32'd0);
    check("overrun_error", 32'(load_error), 32'd1);
    check("overrun_cpu", 32'(cpu_reset_n), 32'd0);
    ack_en = 1'b1;

    // asynchronous reset in the middle of a data word
    do_reset();
    send_byte(MAGIC, 1, 2);
    send_byte(8'h02, 1, 2);
    send_byte(8'h00, 1, 2);
    send_byte(8'hAA, 1, 2);
    send_byte(8'hBB, 1, 2);
    check("mid_data_busy", 32'(busy), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check_all_zero("async_reset");
    do_reset();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
